// File: rtl/serial_pe.sv
// Serial signed dot-product PE: one 16x16 MAC per valid beat, result pulsed after the last beat.
// Define SERIAL_PE_SAT_EN to saturate the accumulator on signed overflow instead of wrapping.
module serial_pe (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] neuron,
   input  logic [15:0] weight,
   input  logic [1:0]  ctl,
   input  logic        vld_i,
   output logic [31:0] result,
   output logic        vld_o
);

   logic signed [31:0] n_ext;
   logic signed [31:0] w_ext;
   logic signed [31:0] prod;
   logic signed [31:0] acc;
   logic signed [31:0] base;
   logic signed [31:0] sum;

   // Sign-extend before multiplying so the low 32 bits are the exact 16x16 product.
   assign n_ext = {{16{neuron[15]}}, neuron};
   assign w_ext = {{16{weight[15]}}, weight};
   assign prod  = n_ext * w_ext;

   // A first beat discards whatever the accumulator held.
   assign base  = ctl[0] ? 32'sd0 : acc;

`ifdef SERIAL_PE_SAT_EN
   logic signed [32:0] sum_ext;

   assign sum_ext = {base[31], base} + {prod[31], prod};

   always_comb begin
      sum = sum_ext[31:0];
      if (sum_ext[32] != sum_ext[31])
         sum = sum_ext[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
   end
`else
   assign sum = base + prod;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         result <= '0;
         vld_o  <= 1'b0;
      end else begin
         vld_o <= vld_i & ctl[1];
         if (vld_i) begin
            acc <= sum;
            if (ctl[1])
               result <= sum;
         end
      end
   end

endmodule

// File: tb/tb_serial_pe.sv
// Directed bench for serial_pe: reset, basic, signed, back-to-back, gaps, overflow, missing-first, mid-vector reset.
module tb_serial_pe;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] neuron;
   logic [15:0] weight;
   logic [1:0]  ctl;
   logic        vld_i;
   logic [31:0] result;
   logic        vld_o;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int last_cyc = 0;
   logic [31:0] pulse_res[$];
   int          pulse_cyc[$];

   serial_pe dut (
      .clk    (clk),
      .rst    (rst),
      .neuron (neuron),
      .weight (weight),
      .ctl    (ctl),
      .vld_i  (vld_i),
      .result (result),
      .vld_o  (vld_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every output pulse with the cycle it was seen in.
   always @(negedge clk) begin
      if (vld_o) begin
         pulse_res.push_back(result);
         pulse_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic beat(input logic [15:0] n, input logic [15:0] w, input logic [1:0] c);
      @(negedge clk);
      neuron = n;
      weight = w;
      ctl    = c;
      vld_i  = 1'b1;
      if (c[1]) last_cyc = cyc;
   endtask

   // Idle cycles carry garbage data and both ctl bits set, all of which must be ignored.
   task automatic idle(input int k);
      repeat (k) begin
         @(negedge clk);
         vld_i  = 1'b0;
         ctl    = 2'b11;
         neuron = 16'($urandom);
         weight = 16'($urandom);
      end
   endtask

   task automatic clear_q();
      pulse_res.delete();
      pulse_cyc.delete();
   endtask

   // Deterministic 12-bit signed data so long vectors cannot overflow 32 bits.
   task automatic vec(input int len, input int seed, input int gap_at, output logic [31:0] gold);
      int nv, wv, p;
      logic [15:0] n, w;
      gold = '0;
      for (int k = 0; k < len; k++) begin
         nv = ((seed * 977 + k * 4099) % 4096) - 2048;
         wv = ((seed * 313 + k * 2711 + 101) % 4096) - 2048;
         n  = 16'(nv);
         w  = 16'(wv);
         if (k == gap_at) idle(5);
         beat(n, w, {k == len - 1, k == 0});
         p    = nv * wv;
         gold = gold + p;
      end
   endtask

   logic [31:0] g [0:3];
   logic [31:0] ga, gb;
   logic [31:0] ovf_exp;

   initial begin
      rst    = 1'b1;
      vld_i  = 1'b1;
      ctl    = 2'b11;
      neuron = '0;
      weight = '0;

      // Reset holds outputs at zero even with valid beats presented.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         neuron = 16'($urandom);
         weight = 16'($urandom);
         ctl    = 2'($urandom);
         #1;
         chk("rst_result", result, 32'h0);
         chk("rst_vld_o", {31'h0, vld_o}, 32'h0);
      end
      @(negedge clk);
      rst   = 1'b0;
      vld_i = 1'b0;

      // Basic: 32 x (1*2) = 64.
      clear_q();
      for (int k = 0; k < 32; k++) beat(16'd1, 16'd2, {k == 31, k == 0});
      idle(3);
      chk("basic_pulses", pulse_res.size(), 1);
      if (pulse_res.size() >= 1) begin
         chk("basic_result", pulse_res[0], 32'h40);
         chk("basic_latency", pulse_cyc[0], last_cyc + 1);
      end
      idle(2);
      chk("basic_hold", result, 32'h40);
      chk("basic_vld_low", {31'h0, vld_o}, 32'h0);

      // Signed length-1 vector: -1 * 3.
      clear_q();
      beat(16'hFFFF, 16'h0003, 2'b11);
      idle(2);
      chk("signed_pulses", pulse_res.size(), 1);
      if (pulse_res.size() >= 1) chk("signed_result", pulse_res[0], 32'hFFFF_FFFD);

      // Back-to-back vectors with no bubbles.
      clear_q();
      vec(32, 1, -1, g[0]);
      vec(64, 2, -1, g[1]);
      vec(96, 3, -1, g[2]);
      vec(32, 4, -1, g[3]);
      idle(3);
      chk("b2b_pulses", pulse_res.size(), 4);
      for (int i = 0; i < 4 && i < pulse_res.size(); i++)
         chk($sformatf("b2b_result%0d", i), pulse_res[i], g[i]);

      // Gap in the middle of a vector must not change the sum.
      clear_q();
      vec(32, 5, -1, ga);
      vec(32, 5, 12, gb);
      idle(3);
      chk("gap_pulses", pulse_res.size(), 2);
      if (pulse_res.size() >= 2) begin
         chk("gap_ref", pulse_res[0], ga);
         chk("gap_result", pulse_res[1], gb);
      end

      // Overflow: 2^30 + 2^30.
`ifdef SERIAL_PE_SAT_EN
      ovf_exp = 32'h7FFF_FFFF;
`else
      ovf_exp = 32'h8000_0000;
`endif
      clear_q();
      beat(16'h8000, 16'h8000, 2'b01);
      beat(16'h8000, 16'h8000, 2'b10);
      idle(3);
      chk("ovf_pulses", pulse_res.size(), 1);
      if (pulse_res.size() >= 1) chk("ovf_result", pulse_res[0], ovf_exp);

      // Missing first flag continues onto the previous sum: 12+30=42, then 42+10=52.
      clear_q();
      beat(16'd3, 16'd4, 2'b01);
      beat(16'd5, 16'd6, 2'b10);
      beat(16'd2, 16'd5, 2'b10);
      idle(3);
      chk("nofirst_pulses", pulse_res.size(), 2);
      if (pulse_res.size() >= 2) begin
         chk("nofirst_r0", pulse_res[0], 32'd42);
         chk("nofirst_r1", pulse_res[1], 32'd52);
      end

      // Mid-vector reset aborts the sum; the next beat starts from zero.
      clear_q();
      beat(16'd100, 16'd100, 2'b01);
      beat(16'd100, 16'd100, 2'b00);
      @(negedge clk);
      vld_i = 1'b0;
      rst   = 1'b1;
      #1;
      chk("midrst_result", result, 32'h0);
      chk("midrst_vld_o", {31'h0, vld_o}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      beat(16'd7, 16'd8, 2'b10);
      idle(3);
      chk("midrst_pulses", pulse_res.size(), 1);
      if (pulse_res.size() >= 1) chk("midrst_sum", pulse_res[0], 32'd56);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_pe.md
SERIAL_PE -- requirements
Module: serial_pe

Interface
REQ-001 The block SHALL have one clock, and reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 neuron  input  16  signed two's-complement activation, one element per beat.
REQ-005 weight  input  16  signed two's-complement weight, one element per beat.
REQ-006 ctl  input  2  ctl[0] = first beat of vector; ctl[1] = last beat of vector; both ignored when vld_i=0.
REQ-007 vld_i  input  1  beat valid; neuron/weight/ctl are sampled only when high.
REQ-008 result  output  32  signed dot-product of the completed vector.
REQ-009 vld_o  output  1  single-cycle pulse marking result valid.
REQ-010 The block SHALL have no parameters, and all widths SHALL be fixed as listed.

Function
REQ-011 Each accepted beat SHALL form a full-precision signed product neuron*weight (16x16 -> 32 bit).
REQ-012 On a beat with ctl[0]=1, the accumulator SHALL load the product, discarding the prior contents.
REQ-013 On a beat with ctl[0]=0, the accumulator SHALL add the product to its contents.
REQ-014 Accumulation SHALL be 32-bit two's complement with modulo-2^32 wrap, unless REQ-025 applies.
REQ-015 On a beat with ctl[1]=1, result SHALL register the final sum, including that beat's product, at that clock edge.
REQ-016 vld_o SHALL be high for exactly the one cycle after the clock edge in REQ-015, giving a latency of 1 cycle from the last beat.
REQ-017 When ctl=2'b11 on one beat (length-1 vector), result SHALL equal that beat's product.
REQ-018 Vector length SHALL be unbounded, 1 or more beats; the supported flow uses multiples of 32.
REQ-019 When vld_i=0, the accumulator, result and ctl handling SHALL hold, and input data SHALL be ignored; gaps are allowed anywhere within a vector.
REQ-020 Back-to-back vectors SHALL be supported: a first beat directly following a last beat SHALL start a fresh sum with no bubble, and the previous result SHALL stay unaffected.
REQ-021 result SHALL hold its value between vld_o pulses.
REQ-022 A vector that is missing ctl[0] SHALL continue accumulating onto the prior sum; no error flag is raised.

Reset
REQ-023 While rst=1, the accumulator SHALL be 0, result SHALL be 32'h0 and vld_o SHALL be 0, independent of clk.
REQ-024 Asserting rst mid-vector SHALL abort the vector; after release, the first accepted beat SHALL begin a new sum regardless of ctl[0], because the accumulator is 0.

Configuration
REQ-025 Macro SERIAL_PE_SAT_EN, when defined, SHALL make accumulation saturate to 32'h7FFFFFFF / 32'h80000000 on signed overflow, using a 33-bit intermediate sum check.
REQ-026 When SERIAL_PE_SAT_EN is undefined, accumulation SHALL wrap per REQ-014, and no saturation logic SHALL be present.

Verification
REQ-027 Reset: hold rst=1 with vld_i=1 and random data -> result=0, vld_o=0 throughout.
REQ-028 Basic: 32 beats with neuron=1 and weight=2, ctl[0] on beat 0 and ctl[1] on beat 31 -> vld_o pulses once, 1 cycle after beat 31, with result=32'h40.
REQ-029 Signed single beat: neuron=16'hFFFF, weight=16'h0003, ctl=2'b11 -> result=32'hFFFFFFFD.
REQ-030 Back-to-back: 4 vectors of lengths 32/64/96/32 with random data and no gaps -> 4 vld_o pulses, each result matching a 32-bit-truncated golden sum.
REQ-031 Gaps: vld_i low for 5 cycles mid-vector with garbage data -> result identical to the gap-free run.
REQ-032 Overflow: two beats of 16'h8000 x 16'h8000 (2^30 each) -> result=32'h80000000 without the macro, and 32'h7FFFFFFF with SERIAL_PE_SAT_EN.
